ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameters SHALL be: INHIBIT_CYCLES, 10000, clock-low hold before request-to-send (100 us at 100 MHz).
REQ-002 TIMEOUT_CYCLES, 2000000, max cycles between device clock falling edges or before first edge (20 ms).
REQ-003 FILTER_LEN, 8, consecutive equal synchronized samples required to accept a ps2 line level change.
REQ-004 Ports SHALL be: clock  in  1  system clock, 100 MHz; sole clock domain.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 tx_data  in  8  command byte to device.
REQ-007 tx_valid  in  1  request; accepted only in the cycle tx_ready=1.
REQ-008 tx_ready  out  1  high only in IDLE.
REQ-009 ps2_clk_in / ps2_data_in  in  1 each  raw pad levels, asynchronous.
REQ-010 ps2_clk_oe / ps2_data_oe  out  1 each  1 = drive line low, 0 = release; tri-state at integration level, open-drain.
REQ-011 tx_done  out  1  one-cycle pulse, byte acknowledged.
REQ-012 tx_error  out  1  one-cycle pulse, NACK or timeout.

Function
REQ-013 Both ps2 inputs SHALL pass a 2-flop synchronizer then FILTER_LEN glitch filter; clock falling edge = filtered level 1->0, one-cycle strobe.
REQ-014 States SHALL be IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE.
REQ-015 IDLE: both oe=0, tx_ready=1; tx_valid in cycle N latches tx_data, computes parity = ~^tx_data, enters INHIBIT at N+1.
REQ-016 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
REQ-017 RTS: clk_oe=1, data_oe=1 for exactly one cycle, then SEND (clk_oe=0, data_oe=1 = start bit).
REQ-018 SEND: 10-bit frame {stop=1, parity, data[7:0]} shifted LSB first; on falling edge k (k=1..10) data_oe SHALL become ~frame[k-1] the next cycle; after edge 10 (stop, line released) enter ACK.
REQ-019 ACK: on the next falling edge sample filtered data: 0 -> WAIT_IDLE with ack_ok; 1 -> WAIT_IDLE with nack.
REQ-020 WAIT_IDLE: when filtered clock and data both high, pulse tx_done (ack_ok) or tx_error (nack), return to IDLE.
REQ-021 Watchdog SHALL clear on entry to SEND and on every falling edge; reaching TIMEOUT_CYCLES in SEND/ACK/WAIT_IDLE releases both lines, pulses tx_error, returns to IDLE same cycle.
REQ-022 tx_valid outside IDLE SHALL be ignored; no queuing; tx_done and tx_error never in the same cycle.
REQ-023 Falling edges in IDLE/INHIBIT/RTS SHALL be ignored.

Reset
REQ-024 reset SHALL asynchronously force IDLE, tx_ready=1, all other outputs 0, counters/shift register/filters cleared (filtered levels =1), including mid-frame.
REQ-025 First post-reset acceptance SHALL not occur before filters settle (FILTER_LEN+2 cycles).

Structure
REQ-026 Package ps2_pkg SHALL hold the state enum, FRAME_BITS=10, default parameter constants.
REQ-027 Sub-module ps2_line_filter (sync + filter + falling strobe) SHALL be instantiated once per ps2 line.
REQ-028 Counter widths SHALL be $clog2 of their parameter +1; no tri-states inside the block.

Verification
REQ-029 tx_data=0xED, device model clocks 12.5 kHz, ACKs -> data bits after start 1,0,1,1,0,1,1,1, parity 1, stop 1; one tx_done pulse.
REQ-030 tx_data=0x01 -> parity 0; tx_data=0x00 -> parity 1; clk_oe high exactly 10000+1 cycles, data_oe rises in cycle N+1+10000.
REQ-031 Device leaves data high at ack edge -> tx_error pulse after lines idle, no tx_done.
REQ-032 Device never clocks -> tx_error exactly 2000000 cycles after SEND entry, both oe=0.
REQ-033 reset asserted after 4th data bit -> oe outputs 0 asynchronously, tx_ready=1; new 0xF4 afterwards completes correctly.
REQ-034 3-cycle glitch on ps2_clk_in and tx_valid pulses while busy -> no bit advance, no second transaction.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, frame size and default timing constants.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam int unsigned FRAME_BITS         = 10;
    localparam int unsigned DEF_INHIBIT_CYCLES = 10000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 2000000;
    localparam int unsigned DEF_FILTER_LEN     = 8;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one PS/2 line, with a falling-edge strobe.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILTER_LEN) + 1;

    logic [1:0]    sync;
    logic [CW-1:0] run_cnt;

    // The filtered level only flips after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync    <= '1;
            run_cnt <= '0;
            level   <= 1'b1;
            fall    <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            fall <= 1'b0;
            if (sync[1] == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                run_cnt <= '0;
                level   <= sync[1];
                fall    <= level;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked frame, ack check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned IW     = $clog2(INHIBIT_CYCLES) + 1;
    localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned BW     = $clog2(FRAME_BITS) + 1;
    localparam int unsigned SETTLE = FILTER_LEN + 2;
    localparam int unsigned SW     = $clog2(SETTLE) + 1;

    state_t                state;
    logic [IW-1:0]         inhibit_cnt;
    logic [TW-1:0]         wd_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  ack_ok;
    logic [SW-1:0]         settle_cnt;
    logic                  settled;
    logic                  timed_out;
    logic                  clk_level, clk_fall;
    logic                  data_level, data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clock   (clock),
        .reset   (reset),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clock   (clock),
        .reset   (reset),
        .line_in (ps2_data_in),
        .level   (data_level),
        .fall    (data_fall_unused)
    );

    // Requests are held off until the filters have flushed their post-reset contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            settle_cnt <= '0;
        else if (!settled)
            settle_cnt <= settle_cnt + SW'(1);
    end

    assign settled   = (settle_cnt == SW'(SETTLE));
    assign timed_out = (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) &&
                       (state inside {SEND, ACK, WAIT_IDLE});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_ready    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            inhibit_cnt <= '0;
            wd_cnt      <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            ack_ok      <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (timed_out) begin
                state       <= IDLE;
                tx_ready    <= 1'b1;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                tx_error    <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b1;
                        if (tx_valid && settled) begin
                            shreg       <= {1'b1, odd_parity(tx_data), tx_data};
                            inhibit_cnt <= '0;
                            tx_ready    <= 1'b0;
                            ps2_clk_oe  <= 1'b1;
                            state       <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inhibit_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                            ps2_data_oe <= 1'b1;
                            state       <= RTS;
                        end else begin
                            inhibit_cnt <= inhibit_cnt + IW'(1);
                        end
                    end
                    RTS: begin
                        ps2_clk_oe <= 1'b0;
                        wd_cnt     <= '0;
                        bit_cnt    <= '0;
                        state      <= SEND;
                    end
                    // Device samples on its rising edge, so the next bit goes out right after each fall.
                    SEND: begin
                        if (clk_fall) begin
                            wd_cnt      <= '0;
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= shreg >> 1;
                            bit_cnt     <= bit_cnt + BW'(1);
                            if (bit_cnt == BW'(FRAME_BITS - 1))
                                state <= ACK;
                        end else begin
                            wd_cnt <= wd_cnt + TW'(1);
                        end
                    end
                    ACK: begin
                        if (clk_fall) begin
                            wd_cnt <= '0;
                            ack_ok <= ~data_level;
                            state  <= WAIT_IDLE;
                        end else begin
                            wd_cnt <= wd_cnt + TW'(1);
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_level && data_level) begin
                            tx_done  <= ack_ok;
                            tx_error <= ~ack_ok;
                            tx_ready <= 1'b1;
                            state    <= IDLE;
                        end else if (clk_fall) begin
                            wd_cnt <= '0;
                        end else begin
                            wd_cnt <= wd_cnt + TW'(1);
                        end
                    end
                    default: begin
                        tx_ready    <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
